// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default timing constants,
// used by both the controller and the peripheral side.
package spi_pkg;

    localparam int unsigned CLK_DIV_DEF   = 32'd4;
    localparam int unsigned FRAME_LEN_DEF = 32'd16;
    localparam int unsigned PAUSE_DEF     = 32'd10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    // Smallest counter width able to hold values 0..max_count-1.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 32'd1) ? $clog2(max_count) : 32'd1;
    endfunction

endpackage

// File: rtl/spi_cfg_master_sck_gen.sv
// SCK generator: half-period counter with registered SCK and rise/fall strobes
// that flag the clk edge on which SCK is about to change.
module sck_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic toggle_en,
    output logic sck,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW       = cnt_width(CLK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sck_q;
    logic          sck_d;

    // Half-period tick, edge strobes and next counter/SCK values.
    always_comb begin
        tick = run && (cnt_q == CNT_LAST);
        rise = tick && toggle_en && !sck_q;
        fall = tick && toggle_en && sck_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (!toggle_en) begin
            sck_d = 1'b0;
        end else if (tick) begin
            sck_d = !sck_q;
        end else begin
            sck_d = sck_q;
        end
    end

    // Counter and SCK registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 configuration master: sends one FRAME_LEN-bit frame MSB first per
// accepted start, captures CIPO in parallel, then enforces an inter-frame gap.
module spi_cfg_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned PAUSE     = PAUSE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [FRAME_LEN-1:0] tx_data,
    output logic                 ready,
    output logic                 done,
    output logic [FRAME_LEN-1:0] rx_data,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);

    localparam int unsigned   BW       = cnt_width(FRAME_LEN);
    localparam int unsigned   PW       = cnt_width(PAUSE);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_LEN - 32'd1);
    localparam logic [PW-1:0] GAP_LAST = PW'(PAUSE - 32'd1);

    spi_state_e           state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [PW-1:0]        gap_q, gap_d;
    logic [FRAME_LEN-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_LEN-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_LEN-1:0] rx_q, rx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 cs_q, cs_d;

    logic accept_s;
    logic run_s;
    logic sck_s;
    logic tick_s;
    logic rise_s;
    logic fall_s;
    logic last_fall_s;

    assign accept_s    = start && ready_q && (state_q == IDLE);
    assign run_s       = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign last_fall_s = fall_s && (bit_q == BIT_LAST);

    sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .toggle_en (state_q == SHIFT),
        .sck       (sck_s),
        .tick      (tick_s),
        .rise      (rise_s),
        .fall      (fall_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_s)          state_d = SETUP; else state_d = IDLE;
            SETUP:   if (tick_s)            state_d = SHIFT; else state_d = SETUP;
            SHIFT:   if (last_fall_s)       state_d = HOLD;  else state_d = SHIFT;
            HOLD:    if (tick_s)            state_d = GAP;   else state_d = HOLD;
            GAP:     if (gap_q == GAP_LAST) state_d = IDLE;  else state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; ready comes up one cycle after entering IDLE.
    always_comb begin
        ready_d = (state_q == IDLE) && !accept_s;
        done_d  = (state_q == HOLD) && tick_s;
        cs_d    = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    end

    // Datapath: shift registers, bit and gap counters, received frame.
    always_comb begin
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        gap_d   = '0;
        if (accept_s) begin
            tx_sh_d = tx_data;
        end else if (fall_s && !last_fall_s) begin
            tx_sh_d = {tx_sh_q[FRAME_LEN-2:0], 1'b0};
        end else begin
            tx_sh_d = tx_sh_q;
        end
        if (rise_s) begin
            rx_sh_d = {rx_sh_q[FRAME_LEN-2:0], CIPO};
        end else begin
            rx_sh_d = rx_sh_q;
        end
        if ((state_q != SHIFT) || last_fall_s) begin
            bit_d = '0;
        end else if (fall_s) begin
            bit_d = bit_q + BW'(1);
        end else begin
            bit_d = bit_q;
        end
        if ((state_q == GAP) && (gap_q != GAP_LAST)) begin
            gap_d = gap_q + PW'(1);
        end else begin
            gap_d = '0;
        end
        if (done_d) begin
            rx_d = rx_sh_q;
        end else begin
            rx_d = rx_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign SCK     = sck_s;
    assign CS      = cs_q;
    assign COPI    = tx_sh_q[FRAME_LEN-1];

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: loopback, peripheral register write,
// back-to-back frames, ignored start, mid-frame reset and a CLK_DIV=2 instance.
module tb_spi_cfg_master;

    localparam int LAT4 = 4 * (2 * 16 + 2) + 1;
    localparam int LAT2 = 2 * (2 * 16 + 2) + 1;
    localparam int PER4 = LAT4 + 10 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    logic        ready, done, sck, cs, copi, cipo;
    logic [15:0] rx_data;
    logic        loop_en = 1'b1;

    logic        start2 = 1'b0;
    logic [15:0] tx2 = 16'h0000;
    logic        ready2, done2, sck2, cs2, copi2;
    logic [15:0] rx2;

    int errors = 0;
    int checks = 0;
    int sck_rises = 0;
    int done_total = 0;

    logic [15:0] per_sh = 16'h0000;
    logic [9:0]  regfile [0:7];

    always #5 clk = ~clk;

    assign cipo = loop_en ? copi : 1'b0;

    spi_cfg_master dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .ready(ready), .done(done), .rx_data(rx_data),
        .SCK(sck), .CS(cs), .COPI(copi), .CIPO(cipo)
    );

    spi_cfg_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2),
        .ready(ready2), .done(done2), .rx_data(rx2),
        .SCK(sck2), .CS(cs2), .COPI(copi2), .CIPO(1'b1)
    );

    always @(posedge sck) if (!cs) sck_rises = sck_rises + 1;
    always @(negedge clk) if (done) done_total = done_total + 1;

    // Peripheral model: {wr, addr[2:0], 2'b00, data[9:0]} latched on CS rise.
    always @(posedge sck) if (!cs) per_sh <= {per_sh[14:0], copi};
    always @(posedge cs) if (per_sh[15] === 1'b1) regfile[per_sh[14:12]] <= per_sh[9:0];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame; optionally pulses start with 0xFFFF at cycle inj.
    task automatic send_frame(input logic [15:0] tx, input int inj, output int lat);
        int n;
        n = 0;
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_before_start", {31'd0, ready}, 32'd1);
        start   = 1'b1;
        tx_data = tx;
        @(negedge clk);
        start = 1'b0;
        check_val("ready_drop", {31'd0, ready}, 32'd0);
        n = 1;
        while (!done && n < 1000) begin
            if (n == inj) begin
                start   = 1'b1;
                tx_data = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        lat = n;
    endtask

    initial begin
        int lat, r0, d0, d1, d2, cs_run, n, s1, s2;
        logic run_end;

        #12;
        check_val("rst_cs", {31'd0, cs}, 32'd1);
        check_val("rst_sck", {31'd0, sck}, 32'd0);
        check_val("rst_copi", {31'd0, copi}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_rx", {16'd0, rx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", {31'd0, ready}, 32'd1);
        check_val("ready2_after_rst", {31'd0, ready2}, 32'd1);

        // Loopback 0xA5C3.
        r0 = sck_rises;
        send_frame(16'hA5C3, 0, lat);
        check_val("lb_lat", lat, LAT4);
        check_val("lb_rx", {16'd0, rx_data}, 32'h0000A5C3);
        check_val("lb_rises", sck_rises - r0, 32'd16);
        check_val("lb_cs_high", {31'd0, cs}, 32'd1);
        repeat (20) @(negedge clk);
        check_val("rx_hold", {16'd0, rx_data}, 32'h0000A5C3);
        check_val("done_one_cycle", {31'd0, done}, 32'd0);

        // Start held high: back-to-back frames.
        n = 0;
        while (!ready && n < 100) begin @(negedge clk); n++; end
        start = 1'b1; tx_data = 16'h1234;
        d1 = -1; d2 = -1; cs_run = 0; run_end = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
                check_val("held_rx", {16'd0, rx_data}, 32'h00001234);
            end
            if (d1 >= 0 && d2 < 0 && !run_end) begin
                if (cs) cs_run++; else run_end = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("held_first_lat", d1, LAT4);
        check_val("held_period", d2 - d1, PER4);
        check_val("held_cs_gap_ge10", {31'd0, (cs_run >= 10)}, 32'd1);
        n = 0;
        while (!(ready && cs) && n < 600) begin @(negedge clk); n++; end

        // Start pulsed mid-SHIFT with different data is ignored.
        d0 = done_total;
        send_frame(16'h3C5A, 40, lat);
        check_val("ign_lat", lat, LAT4);
        check_val("ign_rx", {16'd0, rx_data}, 32'h00003C5A);
        repeat (30) @(negedge clk);
        check_val("ign_no_second", done_total - d0, 32'd1);
        check_val("ign_cs_idle", {31'd0, cs}, 32'd1);

        // Reset at the 7th SCK rise.
        start = 1'b1; tx_data = 16'hABCD;
        @(negedge clk);
        start = 1'b0;
        r0 = sck_rises; d0 = done_total; n = 0;
        while (sck_rises - r0 < 7 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        rst = 1'b0;
        #1;
        check_val("abort_rises", sck_rises - r0, 32'd7);
        check_val("abort_cs", {31'd0, cs}, 32'd1);
        check_val("abort_sck", {31'd0, sck}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_rx", {16'd0, rx_data}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_ready", {31'd0, ready}, 32'd1);
        check_val("abort_no_done", done_total - d0, 32'd0);
        send_frame(16'h00FF, 0, lat);
        check_val("post_abort_lat", lat, LAT4);
        check_val("post_abort_rx", {16'd0, rx_data}, 32'h000000FF);

        // Register write to the peripheral.
        loop_en = 1'b0;
        send_frame(16'h9123, 0, lat);
        check_val("wr_rx_zero", {16'd0, rx_data}, 32'd0);
        check_val("wr_regfile1", {22'd0, regfile[1]}, 32'h00000123);

        // CLK_DIV=2 instance with CIPO tied high.
        n = 0;
        while (!ready2 && n < 100) begin @(negedge clk); n++; end
        start2 = 1'b1; tx2 = 16'h0000;
        @(negedge clk);
        start2 = 1'b0;
        n = 1; s1 = -1; s2 = -1;
        begin
            logic prev;
            prev = sck2;
            while (!done2 && n < 1000) begin
                if (sck2 && !prev) begin
                    if (s1 < 0) s1 = n; else if (s2 < 0) s2 = n;
                end
                prev = sck2;
                @(negedge clk);
                n++;
            end
        end
        check_val("div2_lat", n, LAT2);
        check_val("div2_rx", {16'd0, rx2}, 32'h0000FFFF);
        check_val("div2_sck_period", s2 - s1, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
